// File: rtl/ace_pkg.sv
// Shared widths, FSM state encoding and latched-request payload for the DE2 SRAM controller.
package ace_pkg;

    localparam int unsigned SRAM_ADDR_W = 20;
    localparam int unsigned SRAM_DATA_W = 16;
    localparam int unsigned MEM_W       = 32;
    localparam int unsigned WORD_W      = SRAM_ADDR_W - 1;
    localparam int unsigned BE_W        = MEM_W / 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LO      = 3'd1,
        ST_HI      = 3'd2,
        ST_ACK     = 3'd3,
        ST_RELEASE = 3'd4
    } sram_state_e;

    typedef struct packed {
        logic              write;
        logic [WORD_W-1:0] word;
        logic [MEM_W-1:0]  wdata;
        logic [BE_W-1:0]   be;
    } sram_req_t;

    // SRAM half-word address for a 32-bit word: even half first, odd half second.
    function automatic logic [SRAM_ADDR_W-1:0] half_addr(input logic [WORD_W-1:0] word,
                                                         input logic              hi);
        return {word, hi};
    endfunction

endpackage

// File: rtl/sram_ctrl.sv
// DE2 SRAM controller: each 32-bit word access is a LO then HI 16-bit phase.
// Optional SRAM_BYTE_WRITE_EN adds mem_byte_en lane masking on writes.
module sram_ctrl
    import ace_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [MEM_W-1:0]       mem_addr,
    input  logic [MEM_W-1:0]       mem_write_data,
`ifdef SRAM_BYTE_WRITE_EN
    input  logic [BE_W-1:0]        mem_byte_en,
`endif
    output logic                   mem_ack,
    output logic [MEM_W-1:0]       mem_read_data,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    inout  wire  [SRAM_DATA_W-1:0] sram_dq,
    output logic                   sram_we_n,
    output logic                   sram_oe_n,
    output logic                   sram_ub_n,
    output logic                   sram_lb_n,
    output logic                   sram_ce_n,
    output logic [2:0]             state
);

    localparam int unsigned      CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

    sram_state_e            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    sram_req_t              req_q, req_d;
    logic [SRAM_DATA_W-1:0] rd_lo_q, rd_lo_d;
    logic [MEM_W-1:0]       rdata_d;
    logic                   ack_d;
    logic [SRAM_ADDR_W-1:0] addr_d;
    logic                   we_n_d, oe_n_d, ub_n_d, lb_n_d, ce_n_d;
    logic                   dq_oe_q, dq_oe_d;
    logic [SRAM_DATA_W-1:0] dq_out_q, dq_out_d;
    logic [BE_W-1:0]        be_in;
    logic                   in_phase, hi_phase;
    logic [1:0]             lanes;
    logic                   unused_addr_bits;

`ifdef SRAM_BYTE_WRITE_EN
    assign be_in = mem_byte_en;
`else
    assign be_in = '1;
`endif

    assign unused_addr_bits = ^{mem_addr[MEM_W-1:21], mem_addr[1:0]};
    assign state            = state_q;
    assign sram_dq          = dq_oe_q ? dq_out_q : {SRAM_DATA_W{1'bz}};

    // Next state, then the pin values that the next state will present.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        rd_lo_d = rd_lo_q;
        rdata_d = mem_read_data;
        ack_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mem_read || mem_write) begin
                    req_d.write = !mem_read;
                    req_d.word  = mem_addr[20:2];
                    req_d.wdata = mem_write_data;
                    req_d.be    = be_in;
                    cnt_d       = CNT_LOAD;
                    state_d     = ST_LO;
                end
            end
            ST_LO: begin
                if (cnt_q == '0) begin
                    if (!req_q.write) rd_lo_d = sram_dq;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_HI;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HI: begin
                if (cnt_q == '0) begin
                    if (!req_q.write) rdata_d = {sram_dq, rd_lo_q};
                    ack_d   = 1'b1;
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ACK:     state_d = ST_RELEASE;
            ST_RELEASE: if (!mem_read && !mem_write) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        in_phase = (state_d == ST_LO) || (state_d == ST_HI);
        hi_phase = (state_d == ST_HI);
        lanes    = hi_phase ? req_d.be[3:2] : req_d.be[1:0];
        if (!req_d.write) lanes = 2'b11;

        addr_d   = in_phase ? half_addr(req_d.word, hi_phase) : sram_addr;
        ce_n_d   = !in_phase;
        oe_n_d   = !(in_phase && !req_d.write);
        // Last cycle of a write phase keeps data driven with we_n high as hold time.
        we_n_d   = !(in_phase && req_d.write && (cnt_d != '0));
        lb_n_d   = !(in_phase && lanes[0]);
        ub_n_d   = !(in_phase && lanes[1]);
        dq_oe_d  = in_phase && req_d.write;
        dq_out_d = hi_phase ? req_d.wdata[31:16] : req_d.wdata[15:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            req_q         <= '0;
            rd_lo_q       <= '0;
            mem_ack       <= 1'b0;
            mem_read_data <= '0;
            sram_addr     <= '0;
            sram_we_n     <= 1'b1;
            sram_oe_n     <= 1'b1;
            sram_ub_n     <= 1'b1;
            sram_lb_n     <= 1'b1;
            sram_ce_n     <= 1'b1;
            dq_oe_q       <= 1'b0;
            dq_out_q      <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            req_q         <= req_d;
            rd_lo_q       <= rd_lo_d;
            mem_ack       <= ack_d;
            mem_read_data <= rdata_d;
            sram_addr     <= addr_d;
            sram_we_n     <= we_n_d;
            sram_oe_n     <= oe_n_d;
            sram_ub_n     <= ub_n_d;
            sram_lb_n     <= lb_n_d;
            sram_ce_n     <= ce_n_d;
            dq_oe_q       <= dq_oe_d;
            dq_out_q      <= dq_out_d;
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl (WAIT_CYCLES=1): SRAM device model, transaction-level
// reference model compared every cycle, plus hand-computed literal checks.
module tb_sram_ctrl;

    localparam int unsigned WC    = 1;
    localparam int unsigned PH    = WC + 1;
    localparam int unsigned TOTAL = 2 * PH + 1;
`ifdef SRAM_BYTE_WRITE_EN
    localparam bit BYTE_EN_BUILD = 1'b1;
`else
    localparam bit BYTE_EN_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_write_data;
    logic [3:0]  mem_byte_en;
    logic        mem_ack;
    logic [31:0] mem_read_data;
    logic [19:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n, sram_ce_n;
    logic [2:0]  state;

    int errors = 0;
    int checks = 0;

    sram_ctrl #(.WAIT_CYCLES(WC)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
`ifdef SRAM_BYTE_WRITE_EN
        .mem_byte_en    (mem_byte_en),
`endif
        .mem_ack        (mem_ack),
        .mem_read_data  (mem_read_data),
        .sram_addr      (sram_addr),
        .sram_dq        (sram_dq),
        .sram_we_n      (sram_we_n),
        .sram_oe_n      (sram_oe_n),
        .sram_ub_n      (sram_ub_n),
        .sram_lb_n      (sram_lb_n),
        .sram_ce_n      (sram_ce_n),
        .state          (state)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // SRAM device contents and the bench's own expectation of them.
    logic [15:0] sram_mem [int unsigned];
    logic [15:0] exp_mem  [int unsigned];

    function automatic logic [15:0] sram_get(input int unsigned a);
        return sram_mem.exists(a) ? sram_mem[a] : 16'h0;
    endfunction

    function automatic logic [15:0] exp_get(input int unsigned a);
        return exp_mem.exists(a) ? exp_mem[a] : 16'h0;
    endfunction

    logic tb_drv;
    assign tb_drv  = !sram_ce_n && !sram_oe_n && sram_we_n;
    assign sram_dq = tb_drv ? sram_get(32'(sram_addr)) : 16'bz;

    always @(negedge clk) begin : sram_write
        logic [15:0] w;
        if (reset_n && !sram_ce_n && !sram_we_n) begin
            w = sram_get(32'(sram_addr));
            if (!sram_lb_n) w[7:0]  = sram_dq[7:0];
            if (!sram_ub_n) w[15:8] = sram_dq[15:8];
            sram_mem[32'(sram_addr)] = w;
        end
    end

    // Transaction model: mode 0 idle, 1 busy (m_k cycles since sample), 2 waiting for release.
    int          m_mode;
    int          m_k;
    logic        m_write;
    logic [18:0] m_word;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    logic [31:0] m_rdata;

    task automatic finish_txn();
        logic [15:0] lo, hi;
        lo = exp_get({m_word, 1'b0});
        hi = exp_get({m_word, 1'b1});
        if (m_write) begin
            if (m_be[0]) lo[7:0]  = m_wdata[7:0];
            if (m_be[1]) lo[15:8] = m_wdata[15:8];
            if (m_be[2]) hi[7:0]  = m_wdata[23:16];
            if (m_be[3]) hi[15:8] = m_wdata[31:24];
            exp_mem[{m_word, 1'b0}] = lo;
            exp_mem[{m_word, 1'b1}] = hi;
        end else begin
            m_rdata = {hi, lo};
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode  = 0;
            m_k     = 0;
            m_rdata = '0;
        end else begin
            case (m_mode)
                0: if (mem_read || mem_write) begin
                    m_mode  = 1;
                    m_k     = 1;
                    m_write = !mem_read;
                    m_word  = mem_addr[20:2];
                    m_wdata = mem_write_data;
                    m_be    = BYTE_EN_BUILD ? mem_byte_en : 4'hF;
                end
                1: if (m_k == TOTAL) m_mode = 2;
                   else begin
                       m_k++;
                       if (m_k == TOTAL) finish_txn();
                   end
                default: if (!mem_read && !mem_write) m_mode = 0;
            endcase
        end
    end

    int ack_cnt = 0;
    int we_low_cnt = 0;

    // Per-cycle comparison of every pin against the model.
    always @(negedge clk) begin : compare
        logic       ph, hi;
        int         pos;
        logic [2:0] est;
        logic [1:0] lane;
        if (reset_n) begin
            if (mem_ack) ack_cnt++;
            if (!sram_we_n) we_low_cnt++;
            ph  = (m_mode == 1) && (m_k < TOTAL);
            hi  = (m_k > PH);
            pos = (m_k - 1) % PH;
            if (m_mode == 0)        est = 3'd0;
            else if (m_mode == 2)   est = 3'd4;
            else if (m_k == TOTAL)  est = 3'd3;
            else if (hi)            est = 3'd2;
            else                    est = 3'd1;
            chk("state", 32'(state), 32'(est));
            chk("mem_ack", 32'(mem_ack), 32'(m_mode == 1 && m_k == TOTAL));
            chk("ce_n", 32'(sram_ce_n), 32'(!ph));
            chk("oe_n", 32'(sram_oe_n), 32'(!(ph && !m_write)));
            chk("we_n", 32'(sram_we_n), 32'(!(ph && m_write && pos < WC)));
            chk("mem_read_data", mem_read_data, m_rdata);
            if (ph) begin
                lane = !m_write ? 2'b11 : (hi ? m_be[3:2] : m_be[1:0]);
                chk("sram_addr", 32'(sram_addr), 32'({m_word, hi}));
                chk("lb_n", 32'(sram_lb_n), 32'(!lane[0]));
                chk("ub_n", 32'(sram_ub_n), 32'(!lane[1]));
                if (m_write) chk("dq_write", 32'(sram_dq), 32'(hi ? m_wdata[31:16] : m_wdata[15:0]));
                else         chk("dq_read", 32'(sram_dq), 32'(exp_get({m_word, hi})));
            end
        end
    end

    // One request, held until ack plus hold_after cycles; reports latency, ack-cycle data and final state.
    task automatic txn(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] be, input int hold_after,
                       output int lat, output logic [31:0] ack_data, output logic [2:0] st_held);
        mem_read       = rd;
        mem_write      = wr;
        mem_addr       = addr;
        mem_write_data = data;
        mem_byte_en    = be;
        lat            = 0;
        while (lat < 50) begin
            @(posedge clk); #1;
            lat++;
            if (mem_ack) break;
        end
        chk("ack_seen", 32'(mem_ack), 32'd1);
        ack_data = mem_read_data;
        repeat (hold_after) begin @(posedge clk); #1; end
        st_held   = state;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int          lat;
        logic [31:0] d;
        logic [2:0]  st;
        int          a0, w0;
        int unsigned words [10] = '{0, 1, 2, 3, 8, 9, 12, 13, 20'hFFFFE, 20'hFFFFF};

        mem_read = 0; mem_write = 0; mem_addr = 0; mem_write_data = 0; mem_byte_en = 4'hF;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_ack", 32'(mem_ack), 32'd0);
        chk("rst_rdata", mem_read_data, 32'd0);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_strobes", 32'({sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n, sram_ce_n}), 32'h1F);

        sram_mem[0] = 16'h5678; exp_mem[0] = 16'h5678;
        sram_mem[1] = 16'h1234; exp_mem[1] = 16'h1234;
        sram_mem[2] = 16'h1111; exp_mem[2] = 16'h1111;
        sram_mem[3] = 16'h2222; exp_mem[3] = 16'h2222;
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;

        // Write 0xDEADBEEF to 0x10.
        w0 = we_low_cnt;
        txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, lat, d, st);
        chk("wr_latency", 32'(lat), 32'd5);
        chk("wr_we_low_cycles", 32'(we_low_cnt - w0), 32'd2);
        chk("wr_word8", 32'(sram_get(8)), 32'h0000BEEF);
        chk("wr_word9", 32'(sram_get(9)), 32'h0000DEAD);

        // Read it back; write data on the bus must never reach the SRAM pins.
        txn(1'b1, 1'b0, 32'h10, 32'h0F0F0F0F, 4'hF, 0, lat, d, st);
        chk("rd_latency", 32'(lat), 32'd5);
        chk("rd_data", d, 32'hDEADBEEF);
        chk("rd_word8_intact", 32'(sram_get(8)), 32'h0000BEEF);

        // Read held 10 cycles past ack.
        a0 = ack_cnt;
        txn(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 10, lat, d, st);
        chk("held_ack_count", 32'(ack_cnt - a0), 32'd1);
        chk("held_state", 32'(st), 32'd4);
        txn(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 0, lat, d, st);
        chk("post_release_latency", 32'(lat), 32'd5);
        chk("post_release_data", d, 32'hDEADBEEF);

        // Read and write together at 0x4: read wins.
        txn(1'b1, 1'b1, 32'h4, 32'hCAFEF00D, 4'hF, 0, lat, d, st);
        chk("both_data", d, 32'h22221111);
        chk("both_word2", 32'(sram_get(2)), 32'h00001111);
        chk("both_word3", 32'(sram_get(3)), 32'h00002222);

        // Upper address bits alias; last word of the array.
        txn(1'b0, 1'b1, 32'h0020_0018, 32'h13572468, 4'hF, 0, lat, d, st);
        chk("alias_word12", 32'(sram_get(12)), 32'h00002468);
        chk("alias_word13", 32'(sram_get(13)), 32'h00001357);
        txn(1'b1, 1'b0, 32'h18, 32'h0, 4'hF, 0, lat, d, st);
        chk("alias_read", d, 32'h13572468);
        txn(1'b0, 1'b1, 32'h001F_FFFC, 32'hA5A50F0F, 4'hF, 0, lat, d, st);
        txn(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, 0, lat, d, st);
        chk("last_word_read", d, 32'hA5A50F0F);

        // Reset pulsed during HI of a write.
        a0 = ack_cnt;
        mem_write = 1'b1; mem_addr = 32'h40; mem_write_data = 32'h11112222;
        repeat (3) begin @(posedge clk); #1; end
        chk("abort_in_hi", 32'(state), 32'd2);
        reset_n = 1'b0;
        #1;
        chk("abort_strobes", 32'({sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n, sram_ce_n}), 32'h1F);
        chk("abort_ack", 32'(mem_ack), 32'd0);
        chk("abort_state", 32'(state), 32'd0);
        mem_write = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("abort_idle_after", 32'(state), 32'd0);
        chk("abort_no_ack", 32'(ack_cnt - a0), 32'd0);
        txn(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 0, lat, d, st);
        chk("after_reset_read", d, 32'hDEADBEEF);

`ifdef SRAM_BYTE_WRITE_EN
        txn(1'b0, 1'b1, 32'h0, 32'h00AA0000, 4'b0100, 0, lat, d, st);
        chk("be_latency", 32'(lat), 32'd5);
        chk("be_word1", 32'(sram_get(1)), 32'h000012AA);
        chk("be_word0", 32'(sram_get(0)), 32'h00005678);
`endif

        foreach (words[i]) chk($sformatf("mem_word_%0h", words[i]), 32'(sram_get(words[i])), 32'(exp_get(words[i])));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 The module SHALL have parameter WAIT_CYCLES, default 1, giving the number of SRAM strobe cycles per half-word phase (legal range 1..15).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port mem_read, input, 1 bit: word read request, held until mem_ack.
REQ-005 The module SHALL have port mem_write, input, 1 bit: word write request, held until mem_ack.
REQ-006 The module SHALL have port mem_addr, input, 32 bits: byte address; bits [20:2] select the word and bits [1:0] and [31:21] are ignored.
REQ-007 The module SHALL have port mem_write_data, input, 32 bits: write word.
REQ-008 The module SHALL have port mem_ack, output, 1 bit: one-cycle completion pulse.
REQ-009 The module SHALL have port mem_read_data, output, 32 bits: read word, valid from the mem_ack cycle until the next read completes.
REQ-010 The module SHALL have ports sram_addr (output, 20), sram_dq (inout, 16), and sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n, sram_ce_n (outputs, 1 each): the DE2 SRAM pins.
REQ-011 The module SHALL have port state, output, 3 bits: the current FSM state encoding, for debug LEDs.

Function
REQ-012 The FSM SHALL use states IDLE=0, LO=1, HI=2, ACK=3 and RELEASE=4.
REQ-013 In IDLE, a request sampled high SHALL latch the address and write data and move the FSM to LO; mem_read wins if both mem_read and mem_write are high.
REQ-014 LO SHALL access sram_addr={mem_addr[20:2],1'b0} with low half mem_write_data[15:0]; HI SHALL access {mem_addr[20:2],1'b1} with mem_write_data[31:16].
REQ-015 Each of LO and HI SHALL last WAIT_CYCLES+1 cycles, counted by a 4-bit counter that reloads at each phase entry.
REQ-016 On a read, sram_oe_n SHALL be low for the whole phase, with sram_dq captured in the last cycle of the phase: LO into [15:0], HI into [31:16].
REQ-017 On a write, sram_we_n SHALL be low for the first WAIT_CYCLES cycles of each phase and high in the last cycle (hold); sram_dq SHALL be driven throughout write phases only and be high-Z at all other times.
REQ-018 sram_ce_n SHALL be low only in LO and HI.
REQ-019 ACK SHALL last exactly one cycle with mem_ack=1, after which the FSM goes to RELEASE.
REQ-020 RELEASE SHALL hold until mem_read and mem_write are both low, then go to IDLE, so that a held request is never serviced twice.
REQ-021 Latency: mem_ack SHALL rise 2*(WAIT_CYCLES+1)+1 cycles after the IDLE edge that sampled the request.
REQ-022 Request inputs SHALL be ignored outside IDLE and RELEASE.
REQ-023 Address wrap-around SHALL be silent: word 0x7FFFF is the last word, and higher addresses alias.

Reset
REQ-024 On reset_n low, asynchronously: state=IDLE, mem_ack=0, mem_read_data=0, sram_addr=0, and all SRAM strobes =1.
REQ-025 During reset, sram_dq SHALL be high-Z.
REQ-026 A reset mid-access SHALL abort the access with no mem_ack; a partially written word is permitted.
REQ-027 After reset_n rises, the FSM SHALL resume in IDLE.

Configuration
REQ-028 With macro SRAM_BYTE_WRITE_EN defined, the module SHALL add input mem_byte_en[3:0]: on writes, LO drives lb_n=!be[0] and ub_n=!be[1], and HI drives lb_n=!be[2] and ub_n=!be[3]; a phase with both lanes disabled still takes its full time.
REQ-029 Without SRAM_BYTE_WRITE_EN, the mem_byte_en port SHALL be absent and ub_n/lb_n SHALL be low in LO and HI.
REQ-030 Reads SHALL always enable both byte lanes, regardless of SRAM_BYTE_WRITE_EN.

Structure
REQ-031 The shared package ace_pkg SHALL hold the state encoding type, SRAM_ADDR_W=20, SRAM_DATA_W=16 and MEM_W=32.
REQ-032 No sub-module SHALL be created; the tri-state driver and the phase counter SHALL stay inline.

Verification (WAIT_CYCLES=1)
REQ-033 Bench SHALL check: write addr 0x00000010, data 0xDEADBEEF -> SRAM word 8 = 0xBEEF and word 9 = 0xDEAD; mem_ack at cycle 5; we_n low 1 cycle per phase.
REQ-034 Bench SHALL check: read addr 0x00000010 after the write -> mem_read_data = 0xDEADBEEF in the ack cycle; sram_dq is never driven by the DUT.
REQ-035 Bench SHALL check: mem_read held high 10 cycles after ack -> exactly one mem_ack and state=4 until release; a new read issued after release completes normally.
REQ-036 Bench SHALL check: mem_read and mem_write both high at addr 0x4 -> read performed, SRAM unchanged.
REQ-037 Bench SHALL check: reset_n pulsed low in HI of a write -> all strobes high the same cycle, no mem_ack, state=0.
REQ-038 Bench SHALL check, with SRAM_BYTE_WRITE_EN defined: mem_byte_en=4'b0100, data 0x00AA0000 to addr 0 -> only the low byte of SRAM word 1 becomes 0xAA.
